// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle: hazard/branch/memory inputs and PC-control outputs.
interface fetch_sequencer_if #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   start;
    logic                   halt;
    logic                   stall;
    logic                   branch_taken;
    logic [WIDTH-1:0]       branch_target;
    logic                   mem_ready;
    logic                   mem_req;
    logic                   pc_enable;
    logic                   pc_select;
    logic [WIDTH-1:0]       new_pc;
    logic                   fetch_valid;
    logic                   flush;
    logic                   running;
    logic [COUNT_WIDTH-1:0] fetch_count;

    // Sequencer side
    modport slave (
        input  start, halt, stall, branch_taken, branch_target, mem_ready,
        output mem_req, pc_enable, pc_select, new_pc, fetch_valid, flush,
               running, fetch_count
    );

    // Pipeline/environment side
    modport master (
        output start, halt, stall, branch_taken, branch_target, mem_ready,
        input  mem_req, pc_enable, pc_select, new_pc, fetch_valid, flush,
               running, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: PC enable/select, redirects, halt/resume, flush and fetch counting.
module fetch_sequencer #(
    parameter int unsigned     WIDTH        = 24,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter int unsigned     COUNT_WIDTH  = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    fetch_sequencer_if.slave   bus
);

    localparam int unsigned    FC_W         = 4;
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    logic [FC_W-1:0]        r_flush_cnt;
    logic [COUNT_WIDTH-1:0] r_fetch_count;

    state_t                 w_next_state;
    logic [FC_W-1:0]        w_next_flush_cnt;
    logic                   w_redirect;
    logic                   w_mem_req;
    logic                   w_pc_enable;
    logic                   w_pc_select;
    logic [WIDTH-1:0]       w_new_pc;
    logic                   w_fetch_valid;
    logic                   w_running;
    logic                   w_flush;

    // Next-state and same-cycle PC control decisions
    always_comb begin
        w_next_state     = r_state;
        w_next_flush_cnt = (r_flush_cnt != '0) ? r_flush_cnt - FC_W'(1) : '0;
        w_redirect       = 1'b0;
        w_mem_req        = 1'b0;
        w_pc_enable      = 1'b0;
        w_pc_select      = 1'b0;
        w_new_pc         = '0;
        w_fetch_valid    = 1'b0;
        w_running        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pc_enable  = 1'b1;
                    w_pc_select  = 1'b1;
                    w_new_pc     = RESET_VECTOR;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_mem_req = 1'b1;
                w_running = 1'b1;
                // halt outranks a redirect, which outranks stall/mem_ready
                if (bus.halt) begin
                    w_next_state = S_HALTED;
                end else if (bus.branch_taken) begin
                    w_redirect       = 1'b1;
                    w_pc_enable      = 1'b1;
                    w_pc_select      = 1'b1;
                    w_new_pc         = bus.branch_target;
                    w_next_flush_cnt = FLUSH_RELOAD;
                end else begin
                    w_pc_enable   = bus.mem_ready & ~bus.stall;
                    w_fetch_valid = bus.mem_ready & ~bus.stall;
                end
            end
            S_HALTED: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        w_flush = w_redirect | (r_flush_cnt != '0);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_flush_cnt   <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush_cnt;
            if (w_fetch_valid) begin
                r_fetch_count <= r_fetch_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Everything reads as zero while reset is held, even before the first edge
    assign bus.mem_req     = w_mem_req     & ~i_reset;
    assign bus.pc_enable   = w_pc_enable   & ~i_reset;
    assign bus.pc_select   = w_pc_select   & ~i_reset;
    assign bus.new_pc      = i_reset ? '0 : w_new_pc;
    assign bus.fetch_valid = w_fetch_valid & ~i_reset;
    assign bus.flush       = w_flush       & ~i_reset;
    assign bus.running     = w_running     & ~i_reset;
    assign bus.fetch_count = i_reset ? '0 : r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus randomized run checked against a behavioural fetch-control model.
module tb_fetch_sequencer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned CW    = 4;
    localparam int unsigned FC    = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_sequencer_if #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) bus ();

    fetch_sequencer #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (24'h000000),
        .FLUSH_CYCLES (FC),
        .COUNT_WIDTH  (CW)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.start = 1'b0; bus.halt = 1'b0; bus.stall = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = '0; bus.mem_ready = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled mid-low-phase
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle(); bus.start = 1'b1; bus.mem_ready = 1'b1;
        #1;
        n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL reset_pc_enable: got %0b want 0", bus.pc_enable); end
        n_checks++; if (bus.new_pc !== 24'h0) begin n_fail++; $display("FAIL reset_new_pc: got %0h want 0", bus.new_pc); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b want 0", bus.running); end
        tick();
        rst = 1'b0; bus.start = 1'b0;
        #1;
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL idle_running: got %0b want 0", bus.running); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_mem_req: got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.fetch_count !== 4'd0) begin n_fail++; $display("FAIL idle_fetch_count: got %0d want 0", bus.fetch_count); end
        n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL idle_pc_enable: got %0b want 0", bus.pc_enable); end
        tick();
    endtask

    task automatic test_start();
        bus.start = 1'b1; bus.halt = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 24'h123456;
        #1;
        n_checks++; if (bus.pc_enable !== 1'b1) begin n_fail++; $display("FAIL start_pc_enable: got %0b want 1", bus.pc_enable); end
        n_checks++; if (bus.pc_select !== 1'b1) begin n_fail++; $display("FAIL start_pc_select: got %0b want 1", bus.pc_select); end
        n_checks++; if (bus.new_pc !== 24'h000000) begin n_fail++; $display("FAIL start_new_pc: got %0h want 0", bus.new_pc); end
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL start_flush: got %0b want 0", bus.flush); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %0b want 1", bus.running); end
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL start_mem_req: got %0b want 1", bus.mem_req); end
    endtask

    task automatic test_fetch();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (bus.pc_enable !== 1'b1) begin n_fail++; $display("FAIL fetch_pc_enable[%0d]: got %0b want 1", i, bus.pc_enable); end
            n_checks++; if (bus.pc_select !== 1'b0) begin n_fail++; $display("FAIL fetch_pc_select[%0d]: got %0b want 0", i, bus.pc_select); end
            n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d]: got %0b want 1", i, bus.fetch_valid); end
            tick();
        end
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL wait_pc_enable[%0d]: got %0b want 0", i, bus.pc_enable); end
            n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL wait_fetch_valid[%0d]: got %0b want 0", i, bus.fetch_valid); end
            n_checks++; if (bus.fetch_count !== 4'd5) begin n_fail++; $display("FAIL wait_fetch_count[%0d]: got %0d want 5", i, bus.fetch_count); end
            tick();
        end
        bus.mem_ready = 1'b1; bus.stall = 1'b1;
        #1;
        n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL stall_pc_enable: got %0b want 0", bus.pc_enable); end
        tick();
        drive_idle();
    endtask

    task automatic test_branch();
        bus.stall = 1'b1; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 24'h000040;
        #1;
        n_checks++; if (bus.pc_enable !== 1'b1) begin n_fail++; $display("FAIL br_pc_enable: got %0b want 1", bus.pc_enable); end
        n_checks++; if (bus.pc_select !== 1'b1) begin n_fail++; $display("FAIL br_pc_select: got %0b want 1", bus.pc_select); end
        n_checks++; if (bus.new_pc !== 24'h000040) begin n_fail++; $display("FAIL br_new_pc: got %0h want 40", bus.new_pc); end
        n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL br_fetch_valid: got %0b want 0", bus.fetch_valid); end
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL br_flush0: got %0b want 1", bus.flush); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL br_flush1: got %0b want 1", bus.flush); end
        tick();
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL br_flush2: got %0b want 0", bus.flush); end
    endtask

    task automatic test_back_to_back();
        bus.branch_taken = 1'b1; bus.branch_target = 24'h000020;
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_n: got %0b want 1", bus.flush); end
        tick();
        bus.branch_target = 24'h000080;
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_n1: got %0b want 1", bus.flush); end
        n_checks++; if (bus.new_pc !== 24'h000080) begin n_fail++; $display("FAIL b2b_new_pc: got %0h want 80", bus.new_pc); end
        n_checks++; if (bus.pc_enable !== 1'b1) begin n_fail++; $display("FAIL b2b_pc_enable: got %0b want 1", bus.pc_enable); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_n2: got %0b want 1", bus.flush); end
        tick();
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL b2b_flush_n3: got %0b want 0", bus.flush); end
    endtask

    task automatic test_halt();
        bus.halt = 1'b1; bus.mem_ready = 1'b1;
        #1;
        n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL halt_pc_enable: got %0b want 0", bus.pc_enable); end
        n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_fetch_valid: got %0b want 0", bus.fetch_valid); end
        tick();
        bus.halt = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 24'h000abc;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL halted_mem_req[%0d]: got %0b want 0", i, bus.mem_req); end
            n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL halted_pc_enable[%0d]: got %0b want 0", i, bus.pc_enable); end
            n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL halted_flush[%0d]: got %0b want 0", i, bus.flush); end
            n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL halted_running[%0d]: got %0b want 0", i, bus.running); end
            tick();
        end
        bus.branch_taken = 1'b0; bus.start = 1'b1;
        #1;
        n_checks++; if (bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL resume_no_reload: got %0b want 0", bus.pc_enable); end
        tick();
        bus.start = 1'b0;
        #1;
        n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %0b want 1", bus.running); end
        n_checks++; if (bus.pc_select !== 1'b0) begin n_fail++; $display("FAIL resume_pc_select: got %0b want 0", bus.pc_select); end
        n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL resume_fetch_valid: got %0b want 1", bus.fetch_valid); end
        bus.halt = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.halt = 1'b0;
        #1;
        n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL start_beats_halt: got %0b want 1", bus.running); end
        drive_idle();
    endtask

    task automatic test_wrap();
        rst = 1'b1; drive_idle();
        tick();
        rst = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++; if (bus.fetch_count !== 4'd1) begin n_fail++; $display("FAIL wrap_fetch_count: got %0d want 1", bus.fetch_count); end
    endtask

    task automatic test_reset_mid_flush();
        bus.branch_taken = 1'b1; bus.branch_target = 24'h000100;
        tick();
        bus.branch_taken = 1'b0; rst = 1'b1;
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush_held: got %0b want 0", bus.flush); end
        tick();
        rst = 1'b0; bus.mem_ready = 1'b1;
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush: got %0b want 0", bus.flush); end
        n_checks++; if (bus.fetch_count !== 4'd0) begin n_fail++; $display("FAIL rstmid_fetch_count: got %0d want 0", bus.fetch_count); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req: got %0b want 0", bus.mem_req); end
        tick();
        #1;
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL rstmid_needs_start: got %0b want 0", bus.running); end
        drive_idle();
    endtask

    // Reference model: mode 0 = idle, 1 = fetching, 2 = halted; flush_left counts trailing flush cycles
    task automatic test_random();
        int               mode;
        int               flush_left;
        int               count;
        logic             e_req, e_pe, e_ps, e_fv, e_flush, e_run;
        logic [WIDTH-1:0] e_np;
        logic [CW-1:0]    e_cnt;
        logic             redirect;
        rst = 1'b1; drive_idle();
        tick();
        rst = 1'b0;
        mode = 0; flush_left = 0; count = 0;
        for (int c = 0; c < 600; c++) begin
            rst                = ($urandom_range(0, 99) < 2);
            bus.start          = ($urandom_range(0, 99) < 20);
            bus.halt           = ($urandom_range(0, 99) < 10);
            bus.branch_taken   = ($urandom_range(0, 99) < 20);
            bus.stall          = ($urandom_range(0, 99) < 25);
            bus.mem_ready      = ($urandom_range(0, 99) < 70);
            bus.branch_target  = WIDTH'($urandom);
            e_req = 0; e_pe = 0; e_ps = 0; e_fv = 0; e_run = 0; e_np = '0; redirect = 0;
            if (mode == 0 && bus.start) begin
                e_pe = 1; e_ps = 1; e_np = 24'h000000;
            end else if (mode == 1) begin
                e_req = 1; e_run = 1;
                if (!bus.halt && bus.branch_taken) begin
                    redirect = 1; e_pe = 1; e_ps = 1; e_np = bus.branch_target;
                end else if (!bus.halt) begin
                    e_fv = bus.mem_ready && !bus.stall; e_pe = e_fv;
                end
            end
            e_flush = redirect || (flush_left > 0);
            e_cnt   = CW'(count);
            if (rst) begin
                e_req = 0; e_pe = 0; e_ps = 0; e_fv = 0; e_run = 0; e_np = '0; e_flush = 0; e_cnt = '0;
            end
            #1;
            n_checks++; if (bus.mem_req !== e_req) begin n_fail++; $display("FAIL rnd_mem_req c%0d: got %0b want %0b", c, bus.mem_req, e_req); end
            n_checks++; if (bus.pc_enable !== e_pe) begin n_fail++; $display("FAIL rnd_pc_enable c%0d: got %0b want %0b", c, bus.pc_enable, e_pe); end
            n_checks++; if (bus.pc_select !== e_ps) begin n_fail++; $display("FAIL rnd_pc_select c%0d: got %0b want %0b", c, bus.pc_select, e_ps); end
            n_checks++; if (bus.new_pc !== e_np) begin n_fail++; $display("FAIL rnd_new_pc c%0d: got %0h want %0h", c, bus.new_pc, e_np); end
            n_checks++; if (bus.fetch_valid !== e_fv) begin n_fail++; $display("FAIL rnd_fetch_valid c%0d: got %0b want %0b", c, bus.fetch_valid, e_fv); end
            n_checks++; if (bus.flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush c%0d: got %0b want %0b", c, bus.flush, e_flush); end
            n_checks++; if (bus.running !== e_run) begin n_fail++; $display("FAIL rnd_running c%0d: got %0b want %0b", c, bus.running, e_run); end
            n_checks++; if (bus.fetch_count !== e_cnt) begin n_fail++; $display("FAIL rnd_fetch_count c%0d: got %0d want %0d", c, bus.fetch_count, e_cnt); end
            if (rst) begin
                mode = 0; flush_left = 0; count = 0;
            end else begin
                count      = (count + (e_fv ? 1 : 0)) % (1 << CW);
                flush_left = redirect ? FC - 1 : ((flush_left > 0) ? flush_left - 1 : 0);
                if (mode == 0 && bus.start) mode = 1;
                else if (mode == 1 && bus.halt) mode = 2;
                else if (mode == 2 && bus.start) mode = 1;
            end
            tick();
        end
        rst = 1'b0; drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_start();
        test_fetch();
        test_branch();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block that sequences the fetch stage.
- Drives the PC register's enable, the PC source selector and the redirect address.
- Issues instruction-memory requests, handles stalls, branch redirects, halt/resume and pipeline flush.
- Sits between the fetch datapath, the instruction memory handshake and the hazard/branch logic of later stages.

Parameters:
- WIDTH, 24, PC/address width in bits.
- RESET_VECTOR, 24'h000000, PC loaded on start from IDLE.
- FLUSH_CYCLES, 2, cycles flush is asserted per redirect (legal range 1..15).
- COUNT_WIDTH, 16, width of the fetched-instruction counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin fetching (IDLE) or resume (HALTED)
- halt  in  1  stop fetching
- stall  in  1  downstream hazard; hold PC
- branch_taken  in  1  redirect request from execute
- branch_target  in  WIDTH  redirect address
- mem_ready  in  1  instruction memory has data for current PC this cycle
- mem_req  out  1  request fetch at current PC
- pc_enable  out  1  PC register load enable
- pc_select  out  1  0 = PC+1, 1 = new_pc
- new_pc  out  WIDTH  redirect/load address
- fetch_valid  out  1  instruction delivered to decode this cycle
- flush  out  1  squash wrong-path instructions in decode/execute registers
- running  out  1  state == RUN
- fetch_count  out  COUNT_WIDTH  number of fetch_valid cycles, wraps

Behaviour:
- States: IDLE, RUN, HALTED (registered). Reset → IDLE, flush_cnt=0, fetch_count=0.
- While reset=1, all outputs are 0, including new_pc.
- pc_enable, pc_select, new_pc, mem_req, fetch_valid and flush are combinational from state, flush_cnt and inputs. The PC changes at the same edge the decision is made.
- IDLE:
  - mem_req=0.
  - On start=1: pc_enable=1, pc_select=1, new_pc=RESET_VECTOR; next state RUN.
  - halt, stall and branch_taken are ignored.
- RUN: mem_req=1, running=1. Priority per cycle is halt > branch_taken > stall > normal.
  - halt=1: pc_enable=0, fetch_valid=0; next state HALTED. A pending flush counter keeps counting down.
  - branch_taken=1:
    - pc_enable=1, pc_select=1, new_pc=branch_target, fetch_valid=0. stall and mem_ready are ignored.
    - flush=1 this cycle; flush_cnt <= FLUSH_CYCLES-1.
  - Normal:
    - pc_select=0, new_pc=0.
    - pc_enable = mem_ready & ~stall.
    - fetch_valid = mem_ready & ~stall.
- HALTED:
  - mem_req=0, pc_enable=0.
  - start=1 → RUN, with no PC reload; fetching resumes at the held PC.
  - branch_taken is ignored.
- flush = (state==RUN & branch_taken & ~halt) | (flush_cnt != 0). flush_cnt decrements to 0 each cycle when nonzero, in any state. A new redirect while flush_cnt≠0 reloads it to FLUSH_CYCLES-1.
- fetch_count increments by 1 on every cycle with fetch_valid=1 and wraps modulo 2^COUNT_WIDTH.
- Reset mid-operation: next cycle is IDLE with counters cleared; a new start is required.
- Simultaneous start and halt in HALTED: start is taken. In RUN, start is ignored.

Test Plan:
- Reset, then start=1 for 1 cycle → that cycle pc_enable=1, pc_select=1, new_pc=0x000000; next cycle running=1, mem_req=1.
- RUN with mem_ready=1 and stall=0 for 5 cycles → pc_enable=1 and pc_select=0 each cycle; fetch_valid=1 ×5; fetch_count=5. Then mem_ready=0 for 3 cycles → pc_enable=0, fetch_valid=0, fetch_count stays 5.
- RUN with stall=1 and branch_taken=1, branch_target=0x000040 → that cycle pc_enable=1, pc_select=1, new_pc=0x000040, fetch_valid=0, flush=1. Next cycle flush=1 (FLUSH_CYCLES=2); cycle after that flush=0.
- Branch at cycle N, second branch at N+1 (target 0x000080) → flush high for N, N+1, N+2, then low; PC is loaded with 0x000080 at edge N+1.
- halt=1 in RUN → that cycle pc_enable=0; then HALTED with mem_req=0 for 4 cycles, branch_taken ignored. start=1 → RUN, pc_select=0, no reload.
- fetch_count preset near wrap (COUNT_WIDTH=4, 17 valid fetches) → reads 1. Assert reset mid-RUN during flush → next cycle IDLE, flush=0, fetch_count=0, mem_req=0.
